// File: rtl/latch_bist_pkg.sv
// Shared types and constants for the latch stimulus-and-check engine.
package latch_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    // Taps b7, b5, b4, b3 of x^8+x^6+x^5+x^4+1.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;
    localparam logic [7:0] ERR_MAX   = 8'hFF;

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/latch_bist_lfsr8.sv
// 8-bit left-shifting Fibonacci LFSR with synchronous load and advance.
module lfsr8
    import latch_bist_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] seed,
    input  logic       adv,
    output logic [7:0] val
);

    logic [7:0] val_q;
    logic [7:0] val_d;

    always_comb begin
        val_d = val_q;
        if (load) begin
            val_d = seed;
        end else if (adv) begin
            val_d = lfsr_next(val_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            val_q <= seed;
        end else begin
            val_q <= val_d;
        end
    end

    assign val = val_q;

endmodule

// File: rtl/latch_bist.sv
// Drives pseudo-random enable/data vectors into a D latch and checks its q
// against a cycle-accurate reference model, counting mismatches.
module latch_bist
    import latch_bist_pkg::*;
#(
    parameter int         NUM_STEPS     = 16,
    parameter int         SETTLE_CYCLES = 1,
    parameter logic [7:0] SEED          = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       enb,
    output logic       d,
    input  logic       q,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count
);

    localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam int STEP_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP   = STEP_W'(NUM_STEPS - 1);
    localparam logic [SET_W-1:0]  LAST_SETTLE = SET_W'(SETTLE_CYCLES - 1);

    state_t            state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [SET_W-1:0]  settle_q, settle_d;
    logic              enb_q, enb_d;
    logic              d_q, d_d;
    logic              model_q_q, model_q_d;
    logic              model_valid_q, model_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [7:0]        err_q, err_d;

    logic       lfsr_load;
    logic       lfsr_adv;
    logic [7:0] lfsr_val;
    logic [5:0] lfsr_unused;

    assign lfsr_unused = lfsr_val[7:2];

    lfsr8 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (lfsr_load),
        .seed (SEED_EFF),
        .adv  (lfsr_adv),
        .val  (lfsr_val)
    );

    always_comb begin
        state_d       = state_q;
        step_d        = step_q;
        settle_d      = settle_q;
        enb_d         = enb_q;
        d_d           = d_q;
        model_q_d     = model_q_q;
        model_valid_d = model_valid_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        pass_d        = pass_q;
        err_d         = err_q;
        lfsr_load     = 1'b0;
        lfsr_adv      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy_d    = 1'b0;
                lfsr_load = 1'b1;
                if (start) begin
                    state_d       = ST_DRIVE;
                    step_d        = '0;
                    err_d         = 8'h00;
                    pass_d        = 1'b0;
                    model_valid_d = 1'b0;
                end
            end
            ST_DRIVE: begin
                busy_d   = 1'b1;
                settle_d = '0;
                state_d  = ST_SETTLE;
                // Step 0 writes a known 0 so the latch starts from a defined value.
                if (step_q == '0) begin
                    enb_d = 1'b1;
                    d_d   = 1'b0;
                end else begin
                    enb_d    = lfsr_val[0];
                    d_d      = lfsr_val[1];
                    lfsr_adv = 1'b1;
                end
                if (enb_d) begin
                    model_q_d     = d_d;
                    model_valid_d = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (settle_q == LAST_SETTLE) begin
                    state_d = ST_CHECK;
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            ST_CHECK: begin
                if (model_valid_q && (q != model_q_q) && (err_q != ERR_MAX)) begin
                    err_d = err_q + 8'd1;
                end
                if (step_q == LAST_STEP) begin
                    state_d = ST_FINISH;
                end else begin
                    step_d  = step_q + STEP_W'(1);
                    state_d = ST_DRIVE;
                end
            end
            ST_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                pass_d  = (err_q == 8'h00);
                enb_d   = 1'b0;
                d_d     = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            step_q        <= '0;
            settle_q      <= '0;
            enb_q         <= 1'b0;
            d_q           <= 1'b0;
            model_q_q     <= 1'b0;
            model_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            err_q         <= 8'h00;
        end else begin
            state_q       <= state_d;
            step_q        <= step_d;
            settle_q      <= settle_d;
            enb_q         <= enb_d;
            d_q           <= d_d;
            model_q_q     <= model_q_d;
            model_valid_q <= model_valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            err_q         <= err_d;
        end
    end

    assign enb       = enb_q;
    assign d         = d_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_latch_bist.sv
// Bench for latch_bist: behavioural latches with selectable faults, a run-level
// model of the expected output waveform, and directed runs.
module tb_latch_bist;

    localparam int P   = 3;    // cycles per step with one settle cycle
    localparam int N_A = 16;
    localparam int N_B = 300;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_a = 1'b0;
    logic start_b = 1'b0;

    logic       enb_a, d_a, q_a, busy_a, done_a, pass_a;
    logic [7:0] err_a;
    logic       enb_b, d_b, q_b, busy_b, done_b, pass_b;
    logic [7:0] err_b;

    int   mode_a = 0;   // 0 good latch, 1 inverted q, 2 q tied high
    logic lat_a;
    logic lat_b;

    always #5 clk = ~clk;

    always_latch if (enb_a) lat_a = d_a;
    always_latch if (enb_b) lat_b = d_b;

    assign q_a = (mode_a == 1) ? ~lat_a : (mode_a == 2) ? 1'b1 : lat_a;
    assign q_b = ~lat_b;

    latch_bist #(.NUM_STEPS(N_A), .SETTLE_CYCLES(1), .SEED(8'hA5)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .enb(enb_a), .d(d_a), .q(q_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a)
    );

    latch_bist #(.NUM_STEPS(N_B), .SETTLE_CYCLES(1), .SEED(8'hA5)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .enb(enb_b), .d(d_b), .q(q_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] sw_lfsr(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    // Run-level model for dut_a
    bit vec_enb[N_A];
    bit vec_d[N_A];
    bit ideal[N_A];
    bit m_active = 0;
    int m_c = 0;
    int m_t0 = 0;
    bit m_enb = 0, m_d = 0, m_busy = 0, m_done = 0, m_pass = 0;
    int m_err = 0;
    bit model_on = 0;
    int cyc = 0;
    int done_cnt_a = 0;
    int done_edge_a = -1;
    int busy_cnt_a = 0;

    task automatic build_vectors();
        logic [7:0] x;
        bit prev;
        x = 8'hA5;
        vec_enb[0] = 1'b1;
        vec_d[0]   = 1'b0;
        for (int k = 1; k < N_A; k++) begin
            vec_enb[k] = x[0];
            vec_d[k]   = x[1];
            x = sw_lfsr(x);
        end
        prev = 1'b0;
        for (int k = 0; k < N_A; k++) begin
            if (vec_enb[k]) prev = vec_d[k];
            ideal[k] = prev;
        end
    endtask

    initial forever begin
        int k;
        int ph;
        @(posedge clk);
        cyc++;
        if (rst) begin
            m_active = 0; m_enb = 0; m_d = 0; m_busy = 0; m_done = 0; m_pass = 0; m_err = 0;
        end else if (!m_active) begin
            m_done = 0;
            if (start_a) begin
                m_active = 1; m_c = 0; m_t0 = cyc; m_err = 0; m_pass = 0;
                build_vectors();
            end
        end else begin
            m_c++;
            m_done = 0;
            if (m_c <= N_A * P) begin
                k  = (m_c - 1) / P;
                ph = (m_c - 1) % P;
                m_busy = 1;
                if (ph == 0) begin
                    m_enb = vec_enb[k];
                    m_d   = vec_d[k];
                end
                if (ph == P - 1 && q_a != ideal[k] && m_err < 255) m_err++;
            end else begin
                m_done = 1; m_busy = 0; m_pass = (m_err == 0);
                m_enb = 0; m_d = 0; m_active = 0;
            end
        end
        #1;
        if (model_on) begin
            check("enb", enb_a, m_enb);
            check("d", d_a, m_d);
            check("busy", busy_a, m_busy);
            check("done", done_a, m_done);
            check("pass", pass_a, m_pass);
            check("err_count", err_a, m_err);
        end
        if (busy_a) busy_cnt_a++;
        if (done_a) begin
            done_cnt_a++;
            done_edge_a = cyc - m_t0;
        end
    end

    task automatic pulse_start_a();
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic wait_done_a(input string tag);
        int base;
        base = done_cnt_a;
        for (int i = 0; i < 200; i++) begin
            if (done_cnt_a != base) break;
            @(negedge clk);
        end
        if (done_cnt_a == base) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: no done within 200 cycles", tag);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int tied_exp;
        int b_wait;
        int base;

        repeat (3) @(negedge clk);
        check("rst_enb", enb_a, 0);
        check("rst_d", d_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_pass", pass_a, 0);
        check("rst_err", err_a, 0);
        check("rst_err_b", err_b, 0);
        model_on = 1;
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Clean run with literal vector checks for steps 1 and 2
        mode_a = 0;
        busy_cnt_a = 0;
        pulse_start_a();
        repeat (4) @(negedge clk);
        check("step1_enb", enb_a, 1);
        check("step1_d", d_a, 0);
        repeat (3) @(negedge clk);
        check("step2_enb", enb_a, 0);
        check("step2_d", d_a, 1);
        wait_done_a("clean");
        check("clean_done_edge", done_edge_a, 49);
        check("clean_busy_cycles", busy_cnt_a, 48);
        check("clean_pass", pass_a, 1);
        check("clean_err", err_a, 0);
        repeat (2) @(negedge clk);

        // Inverted latch: every step mismatches
        mode_a = 1;
        pulse_start_a();
        wait_done_a("inv");
        check("inv_done_edge", done_edge_a, 49);
        check("inv_err", err_a, 16);
        check("inv_pass", pass_a, 0);
        repeat (2) @(negedge clk);

        // q tied high: mismatch wherever the latched value should be 0
        mode_a = 2;
        pulse_start_a();
        wait_done_a("tied");
        tied_exp = 0;
        for (int k = 0; k < N_A; k++) if (!ideal[k]) tied_exp++;
        check("tied_err_exact", err_a, tied_exp);
        check("tied_err_nonzero", (err_a >= 8'd1) ? 1 : 0, 1);
        check("tied_pass", pass_a, 0);
        repeat (2) @(negedge clk);

        // 300 steps against an inverted latch: count saturates
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        b_wait = 1;
        while (b_wait <= 1000 && !done_b) begin
            @(negedge clk);
            if (!done_b) b_wait++;
        end
        check("sat_done_edge", b_wait, N_B * P + 1);
        check("sat_err", err_b, 255);
        check("sat_pass", pass_b, 0);
        check("sat_busy", busy_b, 0);
        repeat (2) @(negedge clk);

        // Reset in the middle of an inverted run
        mode_a = 1;
        pulse_start_a();
        repeat (10) @(negedge clk);
        check("mid_err_before_rst", err_a, 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", busy_a, 0);
        check("mid_rst_enb", enb_a, 0);
        check("mid_rst_d", d_a, 0);
        check("mid_rst_err", err_a, 0);
        base = done_cnt_a;
        repeat (60) @(negedge clk);
        check("mid_rst_no_done", done_cnt_a, base);
        mode_a = 0;
        pulse_start_a();
        wait_done_a("after_rst");
        check("after_rst_pass", pass_a, 1);
        check("after_rst_err", err_a, 0);
        repeat (2) @(negedge clk);

        // Second start during a run is ignored
        base = done_cnt_a;
        pulse_start_a();
        repeat (4) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done_a("repulse");
        check("repulse_done_edge", done_edge_a, 49);
        repeat (60) @(negedge clk);
        check("repulse_single_done", done_cnt_a, base + 1);
        check("repulse_pass", pass_a, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/latch_bist.md
# latch_bist

Synthesizable stimulus-and-check engine for a level-sensitive D latch. It sits on the driving side of the latch's `enb`/`d`/`q` interface. On each run it drives a pseudo-random sequence of enable and data values into the latch, keeps a cycle-accurate reference model of latch behaviour, and compares the latch's `q` against that model. It reports busy/done status, pass/fail, and a saturating mismatch count.

## Interface
- `NUM_STEPS`, 16: vectors applied per run; minimum 1.
- `SETTLE_CYCLES`, 1: wait cycles between driving a vector and sampling `q`; minimum 1.
- `SEED`, 8'hA5: LFSR seed; a value of 0 is replaced by 8'h01.
- `clk`  input  1  clock; everything is updated on its rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  run request; sampled only in IDLE.
- `enb`  output  1  latch enable driven to the latch under test.
- `d`  output  1  latch data driven to the latch under test.
- `q`  input  1  latch output, same clock domain.
- `busy`  output  1  high from the cycle after `start` is accepted until `done`.
- `done`  output  1  one-cycle pulse at the end of a run.
- `pass`  output  1  high when the last completed run had `err_count == 0`; held until the next accepted `start`.
- `err_count`  output  8  mismatch count for the current or last run; saturates at 255.

## Operation
- FSM states: IDLE, DRIVE, SETTLE, CHECK, FINISH.
- IDLE:
  - On `start` = 1, go to DRIVE.
  - Clear `err_count`, `pass`, the step counter and `model_valid`.
  - Reload the LFSR with `SEED`.
- DRIVE (1 cycle), registered update of the outputs:
  - Step 0 is forced to `enb` = 1, `d` = 0 to initialise the latch.
  - For steps 1..N-1, `enb` = `lfsr[0]` and `d` = `lfsr[1]`, then the LFSR advances once.
  - Reference model: if `enb` = 1, then `model_q` ← `d` and `model_valid` ← 1; otherwise `model_q` holds.
- SETTLE: hold `enb`/`d` for `SETTLE_CYCLES` cycles, then go to CHECK.
- CHECK (1 cycle):
  - If `model_valid` and `q != model_q`, increment `err_count` unless it is already 255.
  - If the step counter equals `NUM_STEPS`-1, go to FINISH; otherwise increment the step counter and go to DRIVE.
- FINISH (1 cycle):
  - Assert `done`.
  - Set `pass` = (`err_count` == 0), counting any increment from the final CHECK.
  - Drive `enb` = 0 and `d` = 0, then go to IDLE.
- LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1, shifting left. Feedback = `b7^b5^b4^b3`.
- `start` while not in IDLE is ignored; there is no queuing.
- `err_count` arithmetic: 8-bit, saturating, never wraps.

## Timing
- Reset values: `enb` = 0, `d` = 0, `busy` = 0, `done` = 0, `pass` = 0, `err_count` = 0, state = IDLE, LFSR = `SEED` (or 8'h01 if `SEED` is 0).
- Reset mid-run: all outputs return to their reset values on the next edge, with no `done` pulse. `rst` has priority over `start`.
- Per-step length: 2 + `SETTLE_CYCLES` cycles.
- `start` accepted at edge 0:
  - `busy` is high from edge 1.
  - `done` pulses at edge `NUM_STEPS`·(2+`SETTLE_CYCLES`)+1.
  - `busy` falls on that same edge.
- `q` is sampled in the CHECK cycle. It must be stable by `SETTLE_CYCLES` edges after the DRIVE edge.
- `pass` and `done` are valid on the same edge. A new `start` can be accepted the cycle after `done`.

## Structure
- Package `latch_bist_pkg`:
  - FSM state typedef (enum, 3-bit).
  - LFSR tap constant 8'hB8.
  - `ERR_MAX` = 8'hFF.
- Sub-module `lfsr8`: ports `clk`, `rst`, `load`, `seed[7:0]`, `adv`, `val[7:0]`; synchronous reset to seed.
- Top level holds the FSM, step and settle counters, reference model, and error counter. Implementation target is about 150–250 lines total.

## Test plan
- Correct behavioural latch model connected, `NUM_STEPS` = 16, `SETTLE_CYCLES` = 1, `start` pulse at cycle 0 → `done` at cycle 49, `pass` = 1, `err_count` = 0, `busy` high for cycles 1–48.
- Inverted latch (`q` = ~latched value), `NUM_STEPS` = 16 → `err_count` = 16, `pass` = 0.
- `q` tied to 1 → step 0 expects 0, so `err_count` ≥ 1 and `pass` = 0. The bench cross-checks the exact count against a software LFSR model with `SEED` 8'hA5.
- Inverted latch, `NUM_STEPS` = 300 → `err_count` = 255 (saturated, no wrap), `pass` = 0.
- `rst` asserted at cycle 10 of a run → at cycle 11, `busy` = 0, `enb` = `d` = 0, `err_count` = 0, and no `done` ever follows. A subsequent `start` runs a full clean run.
- `start` re-pulsed at cycle 5 during a run → ignored; the single `done` still occurs at cycle 49.
